// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage integer pipeline: EX operand forwarding,
// load-use stalls, taken-branch flushes, memory-wait freeze, perf counters, timeout flag.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd_addr,
  input  logic             id_wb_en,
  input  logic             id_is_load,
  input  logic             id_is_store,
  input  logic             br_taken_ex,
  input  logic             mem_ready,
  output logic [1:0]       mux1_sel,
  output logic [1:0]       mux2_sel,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rd;
    logic       wb_en;
    logic       is_load;
    logic       is_store;
  } slot_t;

  typedef enum logic {StRun, StWait} state_e;

  slot_t ex_q, mem_q, wb_q, ex_d;
  state_e state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic mem_op, mem_fwd_ok, wb_fwd_ok, load_use, stall_ev, flush_ev;

  // MEM stage beats WB; x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic used,
                                         input logic [4:0] mem_rd, input logic mem_ok,
                                         input logic [4:0] wb_rd, input logic wb_ok);
    if (used && mem_ok && (mem_rd == rs)) return 2'b01;
    if (used && wb_ok && (wb_rd == rs))   return 2'b10;
    return 2'b00;
  endfunction

  assign mem_fwd_ok = mem_q.valid & mem_q.wb_en & (mem_q.rd != 5'd0);
  assign wb_fwd_ok  = wb_q.valid & wb_q.wb_en & (wb_q.rd != 5'd0);

  assign mux1_sel = fwd_sel(ex_q.rs1, ex_q.rs1_used, mem_q.rd, mem_fwd_ok, wb_q.rd, wb_fwd_ok);
  assign mux2_sel = fwd_sel(ex_q.rs2, ex_q.rs2_used, mem_q.rd, mem_fwd_ok, wb_q.rd, wb_fwd_ok);

  assign mem_op = mem_q.valid & (mem_q.is_load | mem_q.is_store);
  assign freeze = mem_op & ~mem_ready;

  assign load_use = ex_q.valid & ex_q.is_load & ex_q.wb_en & (ex_q.rd != 5'd0) & id_valid &
                    ((id_rs1_used & (id_rs1_addr == ex_q.rd)) |
                     (id_rs2_used & (id_rs2_addr == ex_q.rd)));

  // Freeze dominates, then branch flush, then load-use stall.
  assign flush_ev = ~freeze & br_taken_ex;
  assign stall_ev = ~freeze & ~br_taken_ex & load_use;

  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (freeze) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
    end else if (br_taken_ex) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    ex_d = '0;
    if (id_valid && !idex_flush) begin
      ex_d = '{valid:    1'b1,
               rs1:      id_rs1_addr,
               rs2:      id_rs2_addr,
               rs1_used: id_rs1_used,
               rs2_used: id_rs2_used,
               rd:       id_rd_addr,
               wb_en:    id_wb_en,
               is_load:  id_is_load,
               is_store: id_is_store};
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StRun: begin
        if (freeze) begin
          state_d    = StWait;
          wait_cnt_d = WaitW'(1);
        end
      end
      StWait: begin
        if (freeze) begin
          if (wait_cnt_q < WaitMax) wait_cnt_d = wait_cnt_q + WaitW'(1);
        end else begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
    mem_err_d = mem_err_q | (wait_cnt_d == WaitMax);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_ev && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      state_q     <= StRun;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!freeze) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= ex_d;
      end
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Slot fields kept for completeness but not consumed by any hazard check.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{ex_q.is_store,
                              mem_q.rs1, mem_q.rs2, mem_q.rs1_used, mem_q.rs2_used,
                              wb_q.rs1, wb_q.rs2, wb_q.rs1_used, wb_q.rs2_used,
                              wb_q.is_load, wb_q.is_store};

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage integer pipeline.
- Keeps its own shadow copy of the register-usage information for the EX, MEM and WB instructions.
- From that copy it drives the EX-stage operand-forwarding selects (mux1_sel/mux2_sel), load-use stalls, taken-branch flushes and whole-pipe freeze while the data memory is not ready.
- Also keeps saturating stall/flush performance counters and a sticky memory-timeout error flag.

Parameters:
- MEM_TIMEOUT, 64, freeze cycles of one memory access after which mem_err sets.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous reset, active-low (asserted at 0).
- id_valid  input  1  ID holds a real instruction.
- id_rs1_addr  input  5  ID source register 1.
- id_rs2_addr  input  5  ID source register 2.
- id_rs1_used  input  1  ID instruction reads rs1.
- id_rs2_used  input  1  ID instruction reads rs2.
- id_rd_addr  input  5  ID destination register.
- id_wb_en  input  1  ID instruction writes rd.
- id_is_load  input  1  ID instruction is a load.
- id_is_store  input  1  ID instruction is a store.
- br_taken_ex  input  1  EX instruction resolved as a taken branch or jump.
- mem_ready  input  1  data memory completes the MEM-stage access this cycle.
- mux1_sel  output  2  EX src1 select: 00 regfile, 01 EX/MEM alu_out, 10 MEM/WB result.
- mux2_sel  output  2  EX src2 select, same encoding as mux1_sel.
- pc_stall  output  1  hold PC.
- ifid_stall  output  1  hold the IF/ID register.
- ifid_flush  output  1  clear IF/ID to a bubble.
- idex_flush  output  1  load a bubble into ID/EX.
- freeze  output  1  hold every pipeline register, including EX/MEM and MEM/WB.
- mem_err  output  1  sticky memory-timeout error.
- stall_cnt  output  CNT_W  load-use stall cycles, saturating.
- flush_cnt  output  CNT_W  branch flush events, saturating.

Behaviour:
- Shadow slots EX, MEM, WB.
  - Each slot holds: valid, rs1, rs2, rs1_used, rs2_used, rd, wb_en, is_load, is_store.
- Slot advance on each rising edge:
  - freeze=1: all slots hold.
  - Otherwise: WB<=MEM, MEM<=EX, and EX<=ID fields.
  - EX instead becomes a bubble (valid=0) when idex_flush=1 or id_valid=0.
- Forwarding, combinational, evaluated for the EX slot; shown for src1, src2 is identical:
  - 01 if MEM.valid & MEM.wb_en & MEM.rd!=0 & MEM.rd==EX.rs1 & EX.rs1_used.
  - Else 10 under the same conditions using the WB slot.
  - Else 00.
  - MEM has priority over WB.
  - rd=x0 is never forwarded.
- Load-use hazard (load_use):
  - Condition: EX.valid & EX.is_load & EX.wb_en & EX.rd!=0 & id_valid & ((id_rs1_used & id_rs1_addr==EX.rd) | (id_rs2_used & id_rs2_addr==EX.rd)).
  - Response: pc_stall=1, ifid_stall=1, idex_flush=1 for exactly one cycle.
  - The next cycle the load sits in MEM and the consumer re-evaluates with no hazard. A later WB forward (10) then supplies the data.
- Branch flush (br_taken_ex=1, not frozen):
  - ifid_flush=1, idex_flush=1; pc_stall=0, ifid_stall=0.
  - Branch beats load-use in the same cycle: stall outputs 0, stall_cnt not incremented.
- Memory freeze:
  - mem_op = MEM.valid & (MEM.is_load | MEM.is_store).
  - freeze = mem_op & ~mem_ready, combinational.
  - While freeze=1: pc_stall=1, ifid_stall=1, ifid_flush=0, idex_flush=0. Branch and load-use responses are suppressed and re-evaluated after the freeze.
  - mux1_sel/mux2_sel still reflect the held slots.
- FSM, 2 states:
  - RUN -> WAIT when freeze=1; wait counter <= 1.
  - WAIT: counter increments each cycle freeze stays 1, saturating at MEM_TIMEOUT.
  - WAIT -> RUN when freeze=0; counter cleared.
  - mem_err sets when the counter reaches MEM_TIMEOUT and is cleared only by reset. The pipeline stays frozen until mem_ready.
- Counters:
  - stall_cnt +1 per load-use stall cycle; flush_cnt +1 per branch flush cycle.
  - Neither counts while frozen. Both saturate at all-ones.
- Reset (rst=0, asynchronous, any time including mid-freeze):
  - All slots invalid, FSM to RUN, wait counter 0, mem_err 0, counters 0.
  - All outputs 0: mux selects 00, no stall, flush or freeze.

Test Plan:
- Back-to-back dependency, ADD x5 then ADD x6,x5,x5 -> second in EX: mux1_sel=01, mux2_sel=01. With one NOP between: 10/10. With rd=x0: 00/00.
- LW x7 then ADD x8,x7,x1 -> one cycle with pc_stall=ifid_stall=idex_flush=1 and stall_cnt=1. Next cycle the ADD enters EX with mux1_sel=10, mux2_sel=00.
- br_taken_ex=1 in the same cycle as a load-use condition -> ifid_flush=idex_flush=1, pc_stall=0, stall_cnt unchanged, flush_cnt=1.
- Store in MEM with mem_ready=0 for 3 cycles -> freeze=1 for exactly 3 cycles with slots and mux selects stable. br_taken_ex asserted during the freeze is ignored until mem_ready=1.
- MEM_TIMEOUT=4, mem_ready held 0 -> mem_err rises on the 4th freeze cycle and stays 1 after mem_ready=1.
- rst driven low mid-freeze, asynchronous to clk -> all outputs 0 immediately; after release the first instruction issues with mux selects 00.
